nco: RTL and testbench

- Numerically controlled oscillator peripheral: generates a square-wave clock output `clk_out_o` whose period is a fixed-point number of `clk_i` cycles (32-bit integer part, 32-bit fractional part).
- Configured by a CPU through an IOb-native CSR slave interface with four registers: SOFT_RESET, ENABLE, PERIOD_INT, PERIOD_FRAC.
- Sits on the system peripheral bus.
- Single clock domain: `clk_out_o` is derived from `clk_i`.

---
 rtl/nco.sv | 136 +++++++++++++
 tb/tb_nco.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nco.sv
// Numerically controlled oscillator with an IOb-native CSR slave.
// Output period is PERIOD_INT + PERIOD_FRAC/2^32 cycles of clk_i.
module nco #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                iob_csrs_iob_valid_i,
  input  logic [ADDR_W-3:0]   iob_csrs_iob_addr_i,
  input  logic [DATA_W-1:0]   iob_csrs_iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_csrs_iob_wstrb_i,
  output logic [DATA_W-1:0]   iob_csrs_iob_rdata_o,
  output logic                iob_csrs_iob_ready_o,
  output logic                iob_csrs_iob_rvalid_o,
  input  logic                iob_csrs_iob_rready_i,
  output logic                clk_out_o
);

  localparam logic [ADDR_W-3:0] A_SRST = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] A_EN   = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] A_INT  = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] A_FRAC = (ADDR_W-2)'(3);

  logic              soft_reset;
  logic              enable;
  logic [DATA_W-1:0] period_int;
  logic [DATA_W-1:0] period_frac;
  logic [DATA_W-1:0] rd_val;
  logic              wr;
  logic              rd;

  logic [DATA_W:0]   cnt;
  logic [DATA_W:0]   n_sh;
  logic [DATA_W:0]   n_cur;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] acc;
  logic              carry;
  logic              halt;
  logic              degen;
  logic              wrap;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0]   old,
    input logic [DATA_W-1:0]   d,
    input logic [DATA_W/8-1:0] s
  );
    merge = old;
    for (int b = 0; b < DATA_W/8; b++)
      if (s[b]) merge[8*b +: 8] = d[8*b +: 8];
  endfunction

  assign iob_csrs_iob_ready_o = 1'b1;
  assign wr = iob_csrs_iob_valid_i & (|iob_csrs_iob_wstrb_i);
  assign rd = iob_csrs_iob_valid_i & ~(|iob_csrs_iob_wstrb_i);

  always_comb begin
    rd_val = '0;
    case (iob_csrs_iob_addr_i)
      A_SRST:  rd_val[0] = soft_reset;
      A_EN:    rd_val[0] = enable;
      A_INT:   rd_val    = period_int;
      A_FRAC:  rd_val    = period_frac;
      default: rd_val    = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      soft_reset            <= 1'b0;
      enable                <= 1'b0;
      period_int            <= '0;
      period_frac           <= '0;
      iob_csrs_iob_rvalid_o <= 1'b0;
      iob_csrs_iob_rdata_o  <= '0;
    end else if (cke_i) begin
      if (wr) begin
        case (iob_csrs_iob_addr_i)
          A_SRST: if (iob_csrs_iob_wstrb_i[0])
                    soft_reset <= iob_csrs_iob_wdata_i[0];
          A_EN:   if (iob_csrs_iob_wstrb_i[0])
                    enable <= iob_csrs_iob_wdata_i[0];
          A_INT:  period_int <= merge(period_int,
                    iob_csrs_iob_wdata_i, iob_csrs_iob_wstrb_i);
          A_FRAC: period_frac <= merge(period_frac,
                    iob_csrs_iob_wdata_i, iob_csrs_iob_wstrb_i);
          default: ;
        endcase
      end
      if (rd) begin
        iob_csrs_iob_rvalid_o <= 1'b1;
        iob_csrs_iob_rdata_o  <= rd_val;
      end else if (iob_csrs_iob_rready_i) begin
        iob_csrs_iob_rvalid_o <= 1'b0;
      end
    end
  end

  // At phase 0 the period is taken live from the CSR; later from the shadow.
  assign n_cur = (cnt == '0)
               ? {1'b0, period_int} + {{DATA_W{1'b0}}, carry}
               : n_sh;
  assign sum   = {1'b0, acc} + {1'b0, period_frac};
  assign halt  = ~enable | soft_reset;
  assign degen = n_cur < (DATA_W+1)'(2);
  assign wrap  = degen | (cnt == n_cur - (DATA_W+1)'(1));

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt       <= '0;
      n_sh      <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      clk_out_o <= 1'b0;
    end else if (cke_i) begin
      if (halt) begin
        cnt       <= '0;
        n_sh      <= '0;
        acc       <= '0;
        carry     <= 1'b0;
        clk_out_o <= 1'b0;
      end else begin
        if (cnt == '0) n_sh <= n_cur;
        clk_out_o <= cnt < (n_cur >> 1);
        if (wrap) begin
          cnt          <= '0;
          {carry, acc} <= sum;
        end else begin
          cnt <= cnt + (DATA_W+1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nco.sv
// Self-checking bench for nco: waveform-queue reference model
// plus directed CSR and period checks.
module tb_nco;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        cke_i = 1'b1;
  logic        valid = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        clk_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_cyc = 0;
  int rises[$];
  int falls[$];
  logic prev_out = 1'b0;

  nco #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk_i                 (clk_i),
    .arst_i                (arst_i),
    .cke_i                 (cke_i),
    .iob_csrs_iob_valid_i  (valid),
    .iob_csrs_iob_addr_i   (addr),
    .iob_csrs_iob_wdata_i  (wdata),
    .iob_csrs_iob_wstrb_i  (wstrb),
    .iob_csrs_iob_rdata_o  (rdata),
    .iob_csrs_iob_ready_o  (ready),
    .iob_csrs_iob_rvalid_o (rvalid),
    .iob_csrs_iob_rready_i (rready),
    .clk_out_o             (clk_out)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: each period is a list of output bits queued up front.
  logic        m_sr, m_en, m_out;
  logic [31:0] m_int, m_frac;
  int          m_c;
  longint      m_n;
  longint unsigned m_fsum;
  bit          mq[$];

  function automatic logic [31:0] bmerge(input logic [31:0] o,
    input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      m_sr = 0; m_en = 0; m_int = 0; m_frac = 0;
      mq.delete(); m_fsum = 0; m_c = 0; m_out = 0;
    end else if (cke_i) begin
      if (!m_en || m_sr) begin
        mq.delete(); m_fsum = 0; m_c = 0; m_out = 0;
      end else begin
        if (mq.size() == 0) begin
          m_n = longint'({32'h0, m_int}) + m_c;
          if (m_n < 2) mq.push_back(1'b0);
          else for (longint i = 0; i < m_n; i++) mq.push_back(i < m_n / 2);
        end
        m_out = mq.pop_front();
        if (mq.size() == 0) begin
          m_c = int'(((m_fsum + m_frac) >> 32) - (m_fsum >> 32));
          m_fsum = m_fsum + m_frac;
        end
      end
      if (valid && wstrb != 0) begin
        case (addr)
          2'd0: if (wstrb[0]) m_sr = wdata[0];
          2'd1: if (wstrb[0]) m_en = wdata[0];
          2'd2: m_int = bmerge(m_int, wdata, wstrb);
          default: m_frac = bmerge(m_frac, wdata, wstrb);
        endcase
      end
    end
  end

  always @(posedge clk_i) begin
    #1;
    cyc++;
    chk("clk_out", clk_out, m_out);
    if (clk_out && !prev_out) rises.push_back(cyc);
    if (!clk_out && prev_out) falls.push_back(cyc);
    prev_out = clk_out;
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    @(negedge clk_i);
    valid = 1; addr = a; wdata = d; wstrb = s;
    @(negedge clk_i);
    valid = 0; wstrb = 0;
    wr_cyc = cyc;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp,
                    input string nm, input bit hold);
    @(negedge clk_i);
    valid = 1; addr = a; wstrb = 0; rready = 0;
    @(negedge clk_i);
    valid = 0;
    chk({nm, "_rvalid"}, rvalid, 1);
    chk({nm, "_rdata"}, rdata, exp);
    if (hold) begin
      @(negedge clk_i);
      chk({nm, "_rvalid_hold"}, rvalid, 1);
      chk({nm, "_rdata_hold"}, rdata, exp);
    end
    rready = 1;
    @(negedge clk_i);
    rready = 0;
    chk({nm, "_rvalid_clr"}, rvalid, 0);
  endtask

  task automatic wait_rises(input int n, input int budget, input string nm);
    for (int i = 0; i < budget && rises.size() < n; i++) @(negedge clk_i);
    chk({nm, "_timeout"}, rises.size() >= n, 1);
  endtask

  task automatic clear_edges();
    rises.delete();
    falls.delete();
  endtask

  int k;

  initial begin
    #500;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    #500;
    arst_i = 0;
    chk("ready", ready, 1);
    for (int a = 0; a < 4; a++) rd(a[1:0], 32'h0, "rst_csr", 0);

    wr(2'd2, 32'h12, 4'hf);
    wr(2'd3, 32'h8000_0000, 4'hf);
    rd(2'd2, 32'h12, "int", 1);
    rd(2'd3, 32'h8000_0000, "frac", 1);
    @(negedge clk_i);
    valid = 1; addr = 2'd2; wstrb = 0;
    @(negedge clk_i);
    addr = 2'd3; rready = 1;
    chk("b2b_first", rdata, 32'h12);
    @(negedge clk_i);
    valid = 0; rready = 0;
    chk("b2b_reissue_rvalid", rvalid, 1);
    chk("b2b_reissue_rdata", rdata, 32'h8000_0000);
    rready = 1;
    @(negedge clk_i);
    rready = 0;

    clear_edges();
    wr(2'd1, 32'h1, 4'hf);
    wait_rises(102, 2500, "frac");
    chk("frac_first_rise", rises[0] - wr_cyc, 1);
    chk("frac_p0", rises[1] - rises[0], 18);
    chk("frac_p1", rises[2] - rises[1], 18);
    chk("frac_p2", rises[3] - rises[2], 19);
    chk("frac_p3", rises[4] - rises[3], 18);
    chk("frac_p4", rises[5] - rises[4], 19);
    chk("frac_high0", falls[0] - rises[0], 9);
    chk("frac_high2", falls[2] - rises[2], 9);
    chk("frac_sum100", rises[101] - rises[1], 1850);

    clear_edges();
    wait_rises(1, 40, "srst_pre");
    wr(2'd0, 32'h1, 4'hf);
    chk("srst_write_edge", clk_out, 1);
    @(negedge clk_i);
    chk("srst_low", clk_out, 0);
    rd(2'd0, 32'h1, "srst_rd", 0);
    repeat (5) @(negedge clk_i);
    clear_edges();
    wr(2'd0, 32'h0, 4'hf);
    wait_rises(2, 60, "srst_post");
    chk("srst_restart", rises[0] - wr_cyc, 1);
    chk("srst_p0", rises[1] - rises[0], 18);
    chk("srst_high", falls[0] - rises[0], 9);

    wr(2'd1, 32'h0, 4'hf);
    wr(2'd2, 32'h4, 4'hf);
    wr(2'd3, 32'h0, 4'hf);
    repeat (2) @(negedge clk_i);
    clear_edges();
    wr(2'd1, 32'h1, 4'hf);
    wait_rises(3, 40, "int4");
    chk("int4_p0", rises[1] - rises[0], 4);
    chk("int4_high", falls[0] - rises[0], 2);
    k = rises.size() - 1;
    wr(2'd2, 32'h6, 4'hf);
    wait_rises(k + 3, 40, "int6");
    chk("int_cur_kept", rises[k+1] - rises[k], 4);
    chk("int6_p", rises[k+2] - rises[k+1], 6);
    chk("int6_high", falls[k+1] - rises[k+1], 3);

    @(negedge clk_i);
    cke_i = 0;
    repeat (5) @(negedge clk_i);
    cke_i = 1;
    repeat (10) @(negedge clk_i);

    wr(2'd1, 32'h0, 4'hf);
    wr(2'd2, 32'h1, 4'hf);
    wr(2'd1, 32'h1, 4'hf);
    repeat (2) @(negedge clk_i);
    clear_edges();
    repeat (20) @(negedge clk_i);
    chk("degen_no_rise", rises.size(), 0);
    chk("degen_low", clk_out, 0);
    wr(2'd3, 32'h4000_0000, 4'hf);
    repeat (40) @(negedge clk_i);
    wr(2'd3, 32'h0, 4'hf);
    wr(2'd2, 32'h8, 4'hf);
    clear_edges();
    wait_rises(1, 40, "dis_pre");
    wr(2'd1, 32'h0, 4'hf);
    chk("dis_write_edge", clk_out, 1);
    @(negedge clk_i);
    chk("dis_low", clk_out, 0);

    wr(2'd2, 32'hAABB_CCDD, 4'b0010);
    rd(2'd2, 32'h0000_CC08, "strobe", 0);
    wr(2'd1, 32'hFFFF_FFFE, 4'hf);
    rd(2'd1, 32'h0, "en_unused", 0);
    wr(2'd0, 32'hFFFF_FFFF, 4'hf);
    rd(2'd0, 32'h1, "srst_unused", 0);
    repeat (3) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
